mul_share_ctrl: RTL

//   Round-robin controller sharing one combinational 16x16 Booth multiplier among NUM_REQ requesters.
//   Per job: accepts one operand pair, registers it onto the multiplier inputs, waits MUL_LAT cycles,

---
 rtl/mul_share_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mul_share_ctrl.sv
// ---------------------------------------------------------------------------
// mul_share_ctrl
//   Round-robin controller that shares one external combinational 16x16
//   multiplier among NUM_REQ requesters. Only one job is in flight at a time.
//   For each job the controller:
//     - accepts one operand pair,
//     - registers the pair onto the multiplier inputs,
//     - holds the inputs for MUL_LAT cycles,
//     - captures result/ov and returns them to the requester that issued the job.
//
// Parameters
//   NUM_REQ : number of requesters (2..8). Requester 0 sits in the LSBs of
//             every packed port.
//   MUL_LAT : number of cycles the multiplier inputs are held stable before
//             the result is sampled (1..7). The multiplier is a multicycle path.
//
// Ports
//   clk, rst_n              : clock (rising edge) and asynchronous active-low reset
//   req_valid / req_ready   : per-requester request handshake (req_ready is one-hot)
//   req_x / req_y           : 16-bit operands per requester, packed
//   mul_x / mul_y           : registered operands driven to the shared multiplier
//   mul_result / mul_ov     : multiplier outputs (low product bits, overflow flag)
//   rsp_valid / rsp_ready   : per-requester response handshake (rsp_valid is one-hot)
//   rsp_result / rsp_ov     : captured result, held until the response is consumed
//   busy                    : high whenever a job is in flight (state != IDLE)
// ---------------------------------------------------------------------------
module mul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_x,
  input  logic [16*NUM_REQ-1:0]   req_y,
  output logic [15:0]             mul_x,
  output logic [15:0]             mul_y,
  input  logic [15:0]             mul_result,
  input  logic                    mul_ov,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [15:0]             rsp_result,
  output logic                    rsp_ov,
  output logic                    busy
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [2:0]     lat_cnt;

  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic [IDW:0]   cand;
  logic [IDW-1:0] next_ptr;

  logic [15:0] x_lane [NUM_REQ];
  logic [15:0] y_lane [NUM_REQ];

  // Unpack the per-requester operand buses.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign x_lane[gi] = req_x[16*gi +: 16];
    assign y_lane[gi] = req_y[16*gi +: 16];
  end

  // Round-robin search: the first valid requester at or after rr_ptr wins.
  // cand is one bit wider so that rr_ptr + k can be wrapped without overflow.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  assign next_ptr = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  // The grant is offered combinationally and only while idle. A held
  // req_valid therefore cannot be accepted twice for the same job.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_id     <= '0;
      lat_cnt    <= '0;
      mul_x      <= '0;
      mul_y      <= '0;
      rsp_result <= '0;
      rsp_ov     <= 1'b0;
      rsp_valid  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A grant always coincides with a handshake, because req_ready
          // is only raised for a lane whose req_valid is high.
          if (gnt_found) begin
            mul_x   <= x_lane[gnt_idx];
            mul_y   <= y_lane[gnt_idx];
            gnt_id  <= gnt_idx;
            rr_ptr  <= next_ptr;
            lat_cnt <= 3'(MUL_LAT);
            state   <= CALC;
          end
        end
        CALC: begin
          // mul_x/mul_y stay untouched. The result is sampled at the end of
          // the MUL_LAT-th cycle during which they have been stable.
          if (lat_cnt == 3'd1) begin
            rsp_result <= mul_result;
            rsp_ov     <= mul_ov;
            rsp_valid  <= NUM_REQ'(1) << gnt_id;
            lat_cnt    <= '0;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          // Only the owner's rsp_ready counts. Other lanes are ignored.
          if (rsp_ready[gnt_id]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
